// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Used by rf_wr_arbiter (optional bypass: RF_WR_BYPASS_EN) and rr_pick.
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             we;
    logic [RF_AW-1:0] wa;
    logic [RF_DW-1:0] wd;
  } rf_wr_t;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

endpackage

// File: rtl/rf_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_valid searching
// upward from i_ptr, wrapping modulo N. Produces a one-hot grant and its index.
module rr_pick
  import rf_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int w_j;
    w_j     = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!o_any && i_valid[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_idx        = PW'(w_j);
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the RF write port among NREQ writeback sources,
// with a one-deep commit register. Optional forwarding compare: RF_WR_BYPASS_EN.
//
// state  | meaning
// IDLE   | no write in flight
// COMMIT | accepted write held in r_wa/r_wd, driven to the RF this cycle
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW,
  parameter int CW   = 16,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wa,
  output logic [DW-1:0]      rf_wd,
  output logic [IW-1:0]      grant_id,
  output logic [CW-1:0]      commit_cnt
`ifdef RF_WR_BYPASS_EN
  ,
  input  logic [AW-1:0]      byp_rs,
  input  logic [AW-1:0]      byp_rt,
  output logic               byp_hit_rs,
  output logic               byp_hit_rt,
  output logic [DW-1:0]      byp_data
`endif
);

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, r_gid, w_idx, w_ptr_nxt;
  logic [AW-1:0]   r_wa;
  logic [DW-1:0]   r_wd;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] w_valid_eff, w_grant;
  logic            w_any, w_accept, w_we;

  // Reset gates the request vector so ready is already low while rst_n is asserted.
  assign w_valid_eff = (stall || !rst_n) ? '0 : req_valid;

  rr_pick #(.N(NREQ), .PW(IW)) u_pick (
    .i_valid (w_valid_eff),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready = w_grant;
  assign w_accept  = w_any;
  assign w_ptr_nxt = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    case (r_state)
      IDLE:   if (w_accept) w_state_nxt = COMMIT;
      COMMIT: begin
        if (!w_accept) w_state_nxt = IDLE;
        w_we = (r_wa != AW'(REG_ZERO));
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ptr <= w_ptr_nxt;
        r_gid <= w_idx;
        r_wa  <= req_addr[int'(w_idx)*AW +: AW];
        r_wd  <= req_data[int'(w_idx)*DW +: DW];
      end
      if (w_we && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign rf_we      = w_we;
  assign rf_wa      = r_wa;
  assign rf_wd      = r_wd;
  assign grant_id   = r_gid;
  assign commit_cnt = r_cnt;

`ifdef RF_WR_BYPASS_EN
  assign byp_hit_rs = w_we && (r_wa == byp_rs);
  assign byp_hit_rt = w_we && (r_wa == byp_rt);
  assign byp_data   = r_wd;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed vector table, reset/async
// sequences, then randomized traffic against a behavioural model.
module tb_rf_wr_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               stall;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rf_we;
  logic [AW-1:0]      rf_wa;
  logic [DW-1:0]      rf_wd;
  logic               grant_id;
  logic [CW-1:0]      commit_cnt;
`ifdef RF_WR_BYPASS_EN
  logic [AW-1:0]      byp_rs, byp_rt;
  logic               byp_hit_rs, byp_hit_rt;
  logic [DW-1:0]      byp_data;
`endif

  int checks = 0;
  int errors = 0;

  rf_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .grant_id   (grant_id),
    .commit_cnt (commit_cnt)
`ifdef RF_WR_BYPASS_EN
    ,
    .byp_rs     (byp_rs),
    .byp_rt     (byp_rt),
    .byp_hit_rs (byp_hit_rs),
    .byp_hit_rt (byp_hit_rt),
    .byp_data   (byp_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [1:0]  v;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        gid;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic gid, input int cnt);
    chk({tag, " rf_we"}, 64'(rf_we), 64'(we));
    chk({tag, " rf_wa"}, 64'(rf_wa), 64'(wa));
    chk({tag, " rf_wd"}, 64'(rf_wd), 64'(wd));
    chk({tag, " grant_id"}, 64'(grant_id), 64'(gid));
    chk({tag, " commit_cnt"}, 64'(commit_cnt), 64'(cnt));
`ifdef RF_WR_BYPASS_EN
    chk({tag, " byp_hit_rs"}, 64'(byp_hit_rs), 64'(we && (wa == byp_rs)));
    chk({tag, " byp_hit_rt"}, 64'(byp_hit_rt), 64'(we && (wa == byp_rt)));
    chk({tag, " byp_data"}, 64'(byp_data), 64'(wd));
`endif
  endtask

  task automatic drive(input logic st, input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    stall     = st;
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  // Model state for the randomized phase
  int          m_ptr, m_cnt;
  logic        m_we, m_gid;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  initial begin
`ifdef RF_WR_BYPASS_EN
    byp_rs = 5'd8;
    byp_rt = 5'd3;
`endif
    // stall, valid, a0, a1, d0, d1 | ready, we, wa, wd, gid, cnt (after the edge)
    vecs.push_back('{0, 2'b01, 5'd8, 5'd0, 32'hDEADBEEF, 32'h0,   2'b01, 1, 5'd8, 32'hDEADBEEF, 0, 0});
    vecs.push_back('{0, 2'b00, 5'd8, 5'd0, 32'hDEADBEEF, 32'h0,   2'b00, 0, 5'd8, 32'hDEADBEEF, 0, 1});
    vecs.push_back('{0, 2'b10, 5'd0, 5'd0, 32'h0, 32'h1234,       2'b10, 0, 5'd0, 32'h1234,     1, 1});
    vecs.push_back('{0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h1234,       2'b00, 0, 5'd0, 32'h1234,     1, 1});
    vecs.push_back('{0, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1,        2'b01, 1, 5'd3, 32'hA0,       0, 1});
    vecs.push_back('{0, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1,        2'b10, 1, 5'd4, 32'hB1,       1, 2});
    vecs.push_back('{0, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1,        2'b01, 1, 5'd3, 32'hA0,       0, 3});
    vecs.push_back('{0, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1,        2'b10, 1, 5'd4, 32'hB1,       1, 4});
    vecs.push_back('{0, 2'b00, 5'd3, 5'd4, 32'hA0, 32'hB1,        2'b00, 0, 5'd4, 32'hB1,       1, 5});
    vecs.push_back('{1, 2'b01, 5'd9, 5'd0, 32'hCAFE0009, 32'h0,   2'b00, 0, 5'd4, 32'hB1,       1, 5});
    vecs.push_back('{1, 2'b01, 5'd9, 5'd0, 32'hCAFE0009, 32'h0,   2'b00, 0, 5'd4, 32'hB1,       1, 5});
    vecs.push_back('{1, 2'b01, 5'd9, 5'd0, 32'hCAFE0009, 32'h0,   2'b00, 0, 5'd4, 32'hB1,       1, 5});
    vecs.push_back('{0, 2'b01, 5'd9, 5'd0, 32'hCAFE0009, 32'h0,   2'b01, 1, 5'd9, 32'hCAFE0009, 0, 5});
    // stall raised while the write above is in COMMIT: it must still land
    vecs.push_back('{1, 2'b11, 5'd9, 5'd10, 32'hCAFE0009, 32'h77, 2'b00, 0, 5'd9, 32'hCAFE0009, 0, 6});
    vecs.push_back('{0, 2'b00, 5'd9, 5'd10, 32'hCAFE0009, 32'h77, 2'b00, 0, 5'd9, 32'hCAFE0009, 0, 6});

    // Reset held with all requesters valid
    rst_n = 1'b0;
    drive(0, 2'b11, 5'd1, 5'd2, 32'h11, 32'h22);
    repeat (2) @(negedge clk);
    chk("reset ready", 64'(req_ready), 64'(2'b00));
    chk_out("reset", 0, 5'd0, 32'h0, 0, 0);
    #1 rst_n = 1'b1;
    #1 chk("first grant after reset", 64'(req_ready), 64'(2'b01));
    req_valid = 2'b00;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      @(negedge clk);
      chk($sformatf("vec%0d ready", i), 64'(req_ready), 64'(vecs[i].rdy));
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].gid, vecs[i].cnt);
    end

    // Async reset in the middle of a commit
    drive(0, 2'b01, 5'd12, 5'd0, 32'h1200000C, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    chk("pre-async rf_we", 64'(rf_we), 64'(1));
    chk("pre-async rf_wa", 64'(rf_wa), 64'(12));
    req_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("async rf_we", 64'(rf_we), 64'(0));
    chk("async ready", 64'(req_ready), 64'(0));
    chk("async commit_cnt", 64'(commit_cnt), 64'(0));
    chk("async rf_wa", 64'(rf_wa), 64'(0));
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the behavioural model
    m_ptr = 0; m_cnt = 0; m_we = 0; m_gid = 0; m_wa = '0; m_wd = '0;
    begin
      logic [4:0]  ca[NREQ];
      logic [31:0] cd[NREQ];
      logic [1:0]  cv;
      bit          pend[NREQ];
      foreach (pend[i]) begin pend[i] = 0; ca[i] = '0; cd[i] = '0; end
      cv = '0;
      for (int c = 0; c < 400; c++) begin
        logic       st;
        logic [1:0] er;
        int         gi;
        st = ($urandom % 5 == 0);
        for (int i = 0; i < NREQ; i++) begin
          if (pend[i] && ($urandom % 4 != 0)) cv[i] = 1'b1;
          else begin
            cv[i] = 1'($urandom % 2);
            ca[i] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom % 32);
            cd[i] = $urandom;
          end
        end
        drive(st, cv, ca[0], ca[1], cd[0], cd[1]);
        gi = -1;
        if (!st)
          for (int k = 0; k < NREQ; k++)
            if (gi < 0 && cv[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
        er = (gi >= 0) ? 2'(1 << gi) : 2'b00;
        @(negedge clk);
        chk($sformatf("rand%0d ready", c), 64'(req_ready), 64'(er));
        @(posedge clk); #1;
        if (m_we && m_cnt < CMAX) m_cnt++;
        if (gi >= 0) begin
          m_wa  = ca[gi];
          m_wd  = cd[gi];
          m_gid = 1'(gi);
          m_we  = (ca[gi] != 5'd0);
          m_ptr = (gi + 1) % NREQ;
        end else m_we = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = cv[i] && (gi != i);
        chk_out($sformatf("rand%0d", c), m_we, m_wa, m_wd, m_gid, m_cnt);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
